// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives the PSRAM-clock PLL reset, watches its lock output,
// and releases downstream logic once lock has been continuously stable.
// Runs from the free-running board oscillator, never from a PLL output.
// Optional build macro: PLL_LOCK_LOSS_COUNT_EN adds loss_cnt / lock_lost outputs.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 27000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       timeout,
`ifdef PLL_LOCK_LOSS_COUNT_EN
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic       lock_lost
`else
  output logic [7:0] retry_cnt
`endif
);

  localparam int unsigned       SAT_W       = 8;
  localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 32'd1);
  localparam logic [SAT_W-1:0]  SAT_MAX     = '1;

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               pll_reset_q, pll_reset_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               timeout_q, timeout_d;
  logic [SAT_W-1:0]   retry_cnt_q, retry_cnt_d;
  logic               lock_s;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [SAT_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic               lock_lost_q, lock_lost_d;
`endif

  assign lock_s = sync2_q;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_comb begin
    sync1_d = pll_lock;
    sync2_d = sync1_q;
  end

  // Next-state, shared counter and registered Moore outputs
  always_comb begin
    state_d     = state_q;
    timeout_d   = 1'b0;
    retry_cnt_d = retry_cnt_q;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    loss_cnt_d  = loss_cnt_q;
    lock_lost_d = lock_lost_q;
`endif
    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock wins over the timeout when both land on the same cycle
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = S_PLL_RST;
          timeout_d = 1'b1;
          if (retry_cnt_q != SAT_MAX) retry_cnt_d = retry_cnt_q + SAT_W'(1);
        end
      end
      S_STABLE: begin
        // A lock glitch restarts the stability wait without resetting the PLL
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_PLL_RST;
`ifdef PLL_LOCK_LOSS_COUNT_EN
          if (loss_cnt_q != SAT_MAX) loss_cnt_d = loss_cnt_q + SAT_W'(1);
          lock_lost_d = 1'b1;
`endif
        end
      end
      default: state_d = S_PLL_RST;
    endcase

    cnt_d       = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    pll_reset_d = (state_d == S_PLL_RST);
    sys_rst_d   = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
  end

  // State, counter, synchronizer and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      timeout_q   <= 1'b0;
      retry_cnt_q <= '0;
`ifdef PLL_LOCK_LOSS_COUNT_EN
      loss_cnt_q  <= '0;
      lock_lost_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      timeout_q   <= timeout_d;
      retry_cnt_q <= retry_cnt_d;
`ifdef PLL_LOCK_LOSS_COUNT_EN
      loss_cnt_q  <= loss_cnt_d;
      lock_lost_q <= lock_lost_d;
`endif
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign timeout   = timeout_q;
  assign retry_cnt = retry_cnt_q;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  assign loss_cnt  = loss_cnt_q;
  assign lock_lost = lock_lost_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer: randomized lock/reset stimulus, a
// behavioural model pushing expected outputs into a scoreboard each cycle,
// and a monitor comparing DUT outputs on the falling edge.
module tb_pll_lock_sequencer;

  localparam int unsigned RSTC = 4;
  localparam int unsigned TMO  = 20;
  localparam int unsigned STB  = 8;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STB  = 2;
  localparam int P_RUN  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset, sys_rst, ready, timeout;
  logic [7:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0] loss_cnt;
  logic       lock_lost;
`endif

  pll_lock_sequencer #(
    .RST_CYCLES    (RSTC),
    .TIMEOUT_CYCLES(TMO),
    .STABLE_CYCLES (STB),
    .CNT_W         (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pll_lock (pll_lock),
    .pll_reset(pll_reset),
    .sys_rst  (sys_rst),
    .ready    (ready),
    .timeout  (timeout),
`ifdef PLL_LOCK_LOSS_COUNT_EN
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt),
    .lock_lost(lock_lost)
`else
    .retry_cnt(retry_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pr;
    bit sr;
    bit rd;
    bit to;
    int retry;
    int loss;
    bit lost;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model: phase, cycles spent in phase, and a 2-deep lock sample pipeline
  int m_phase = P_RST;
  int m_age   = 0;
  int m_retry = 0;
  int m_loss  = 0;
  bit m_lost  = 1'b0;
  bit m_tmo   = 1'b0;
  bit pipe[$];

  function automatic exp_t snapshot();
    exp_t e;
    e.pr    = (m_phase == P_RST);
    e.sr    = (m_phase != P_RUN);
    e.rd    = (m_phase == P_RUN);
    e.to    = m_tmo;
    e.retry = m_retry;
    e.loss  = m_loss;
    e.lost  = m_lost;
    return e;
  endfunction

  task automatic model_reset();
    m_phase = P_RST;
    m_age   = 0;
    m_retry = 0;
    m_loss  = 0;
    m_lost  = 1'b0;
    m_tmo   = 1'b0;
    pipe    = {1'b0, 1'b0};
    sb.delete();
    sb.push_back(snapshot());
  endtask

  task automatic model_step();
    bit ls;
    int nxt;
    int spent;
    ls = pipe.pop_front();
    pipe.push_back(pll_lock);
    spent = m_age + 1;
    nxt   = m_phase;
    m_tmo = 1'b0;
    case (m_phase)
      P_RST:  if (spent == int'(RSTC)) nxt = P_WAIT;
      P_WAIT: begin
        if (ls) nxt = P_STB;
        else if (spent == int'(TMO)) begin
          nxt   = P_RST;
          m_tmo = 1'b1;
          if (m_retry < 255) m_retry++;
        end
      end
      P_STB: begin
        if (!ls) nxt = P_WAIT;
        else if (spent == int'(STB)) nxt = P_RUN;
      end
      default: begin
        if (!ls) begin
          nxt    = P_RST;
          m_lost = 1'b1;
          if (m_loss < 255) m_loss++;
        end
      end
    endcase
    m_age   = (nxt != m_phase) ? 0 : spent;
    m_phase = nxt;
    sb.push_back(snapshot());
  endtask

  // Reference model advances on every edge; reset acts immediately
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest scoreboard entry
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_empty at %0t: got none expected one entry", $time);
    end else begin
      e = sb.pop_front();
      chk("pll_reset", 32'(pll_reset), 32'(e.pr));
      chk("sys_rst",   32'(sys_rst),   32'(e.sr));
      chk("ready",     32'(ready),     32'(e.rd));
      chk("timeout",   32'(timeout),   32'(e.to));
      chk("retry_cnt", 32'(retry_cnt), 32'(e.retry));
`ifdef PLL_LOCK_LOSS_COUNT_EN
      chk("loss_cnt",  32'(loss_cnt),  32'(e.loss));
      chk("lock_lost", 32'(lock_lost), 32'(e.lost));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_phase(input int ph, input int min_age, input int budget, input string nm);
    int k;
    k = 0;
    while (!(m_phase == ph && m_age >= min_age) && k < budget) begin
      tick(1);
      k++;
    end
    n_vec++;
    if (k >= budget) begin
      n_bad++;
      $display("FAIL wait_%s: got no phase %0d within %0d cycles expected reached", nm, ph, budget);
    end
  endtask

  task automatic async_reset_check(input int hold);
    rst = 1'b1;
    #1;
    chk("async_pll_reset", 32'(pll_reset), 32'd1);
    chk("async_sys_rst",   32'(sys_rst),   32'd1);
    chk("async_ready",     32'(ready),     32'd0);
    chk("async_retry",     32'(retry_cnt), 32'd0);
    #1;
    tick(hold);
    rst = 1'b0;
  endtask

  initial begin
    // Reset, then no lock: repeated timeouts and retries
    tick(3);
    rst = 1'b0;
    tick(3 * int'(RSTC + TMO) + 6);

    // Lock arrives mid wait and stays: reach RUN
    wait_phase(P_WAIT, 4, 60, "wait1");
    pll_lock = 1'b1;
    wait_phase(P_RUN, 0, 60, "run1");
    tick(5);

    // Lose lock in RUN, then relock
    pll_lock = 1'b0;
    tick(12);
    wait_phase(P_WAIT, 0, 60, "wait2");
    pll_lock = 1'b1;

    // One-cycle glitch while lock is proving stable
    wait_phase(P_STB, 3, 60, "stb");
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    wait_phase(P_RUN, 0, 80, "run2");
    tick(4);

    // Asynchronous reset mid-RUN, then full bring-up again
    async_reset_check(2);
    wait_phase(P_RUN, 0, 100, "run3");
    tick(3);

    // Random lock activity with occasional resets
    for (int s = 0; s < 60; s++) begin
      pll_lock = ($urandom_range(0, 2) != 0);
      tick(int'($urandom_range(1, 30)));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        tick(int'($urandom_range(1, 2)));
        rst = 1'b0;
      end
    end

    // Long lock absence to saturate retry_cnt
    pll_lock = 1'b0;
    tick(256 * int'(RSTC + TMO) + 10);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
